axis_mux: RTL and testbench

AXIS_MUX -- requirements
Module: axis_mux

---
 rtl/axis_mux_pkg.sv | 16 +
 rtl/axis_skid_buffer.sv | 51 +++++
 rtl/axis_mux.sv | 81 ++++++++
 tb/tb_axis_mux.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/axis_mux_pkg.sv
// Shared constants for the 2:1 AXI-Stream mux: default payload widths
// and the encoding of the channel select input.
package axis_mux_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_FRAC_WIDTH = 14;
  localparam int DEFAULT_INT_WIDTH  = 2;

  // Select encoding for input s
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // A beat carries payload plus tlast plus the 1-bit sideband flag
  localparam int BEAT_EXTRA_BITS = 2;

endpackage

// File: rtl/axis_skid_buffer.sv
// Registered skid buffer: one main output register plus one skid register.
// in_ready depends only on the skid state, so upstream ready never sees a
// combinational path from out_ready.
module axis_skid_buffer #(
  parameter int width = 18
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [width-1:0] in_beat,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [width-1:0] out_beat,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [width-1:0] main_reg;
  logic             main_valid_reg;
  logic [width-1:0] skid_reg;
  logic             skid_valid_reg;

  assign in_ready  = ~skid_valid_reg;
  assign out_beat  = main_reg;
  assign out_valid = main_valid_reg;

  // Main register refills from skid first (preserving order), then from input;
  // a beat accepted while the output is stalled parks in the skid register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_reg       <= '0;
      main_valid_reg <= 1'b0;
      skid_reg       <= '0;
      skid_valid_reg <= 1'b0;
    end else if (!main_valid_reg || out_ready) begin
      if (skid_valid_reg) begin
        main_reg       <= skid_reg;
        main_valid_reg <= 1'b1;
      end else if (in_valid) begin
        main_reg       <= in_beat;
        main_valid_reg <= 1'b1;
      end else begin
        main_valid_reg <= 1'b0;
      end
      skid_valid_reg <= 1'b0;
    end else if (in_valid) begin
      skid_reg       <= in_beat;
      skid_valid_reg <= 1'b1;
    end
  end

endmodule

// File: rtl/axis_mux.sv
// 2:1 AXI-Stream mux. s picks the channel offered ready each cycle; the
// accepted beat {payload, tlast, sideband} is passed untouched into a
// registered skid buffer, so buffered beats keep their original source.
module axis_mux
  import axis_mux_pkg::*;
#(
  parameter int data_width = DEFAULT_DATA_WIDTH,
  parameter int frac_width = DEFAULT_FRAC_WIDTH,
  parameter int int_width  = DEFAULT_INT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [data_width-1:0] a,
  input  logic [data_width-1:0] b,
  input  logic                  s,
  input  logic                  tvalid_in_a,
  input  logic                  tvalid_in_b,
  input  logic                  tlast_in_a,
  input  logic                  tlast_in_b,
  input  logic                  tdata_in_a,
  input  logic                  tdata_in_b,
  output logic                  tready_out_a,
  output logic                  tready_out_b,
  output logic [data_width-1:0] o,
  output logic                  tvalid_out,
  output logic                  tlast_out,
  output logic                  tdata_out,
  input  logic                  tready_in
);

  // Payload is Q(int_width.frac_width); the two must add up to data_width.
  // The mux never interprets the value, it only routes the bits.
  localparam int q_width = int_width + frac_width;
  localparam int beat_w  = q_width + BEAT_EXTRA_BITS;

  logic [1:0]        ch_valid;
  logic [1:0]        ch_ready;
  logic [beat_w-1:0] ch_beat [2];
  logic [beat_w-1:0] sel_beat;
  logic [beat_w-1:0] out_beat;
  logic              sel_valid;
  logic              buf_ready;
  logic              accept;

  assign ch_valid   = {tvalid_in_b, tvalid_in_a};
  assign ch_beat[0] = {a, tlast_in_a, tdata_in_a};
  assign ch_beat[1] = {b, tlast_in_b, tdata_in_b};

  // Only the selected channel sees ready; held low while reset is asserted
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan_ready
      assign ch_ready[gi] = ~reset & buf_ready & (s == 1'(gi));
    end
  endgenerate

  assign tready_out_a = ch_ready[0];
  assign tready_out_b = ch_ready[1];

  assign sel_beat  = (s == SEL_B) ? ch_beat[1] : ch_beat[0];
  assign sel_valid = (s == SEL_B) ? ch_valid[1] : ch_valid[0];
  assign accept    = sel_valid & (ch_ready[0] | ch_ready[1]);

  axis_skid_buffer #(
    .width(beat_w)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .in_beat  (sel_beat),
    .in_valid (accept),
    .in_ready (buf_ready),
    .out_beat (out_beat),
    .out_valid(tvalid_out),
    .out_ready(tready_in)
  );

  assign o         = out_beat[beat_w-1:BEAT_EXTRA_BITS];
  assign tlast_out = out_beat[1];
  assign tdata_out = out_beat[0];

endmodule

// File: tb/tb_axis_mux.sv
// Directed testbench for axis_mux: reset, channel select, tlast isolation,
// backpressure through the skid register, and mid-stream reset.
module tb_axis_mux;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] a, b;
  logic        s;
  logic        tvalid_in_a, tvalid_in_b;
  logic        tlast_in_a, tlast_in_b;
  logic        tdata_in_a, tdata_in_b;
  logic        tready_out_a, tready_out_b;
  logic [15:0] o;
  logic        tvalid_out, tlast_out, tdata_out;
  logic        tready_in;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axis_mux dut (
    .clk         (clk),
    .reset       (reset),
    .a           (a),
    .b           (b),
    .s           (s),
    .tvalid_in_a (tvalid_in_a),
    .tvalid_in_b (tvalid_in_b),
    .tlast_in_a  (tlast_in_a),
    .tlast_in_b  (tlast_in_b),
    .tdata_in_a  (tdata_in_a),
    .tdata_in_b  (tdata_in_b),
    .tready_out_a(tready_out_a),
    .tready_out_b(tready_out_b),
    .o           (o),
    .tvalid_out  (tvalid_out),
    .tlast_out   (tlast_out),
    .tdata_out   (tdata_out),
    .tready_in   (tready_in)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; s = 1'b0; a = '0; b = '0;
    tvalid_in_a = 0; tvalid_in_b = 0; tlast_in_a = 0; tlast_in_b = 0;
    tdata_in_a = 0; tdata_in_b = 0; tready_in = 1'b1;
    tick(); tick();
    checks++; if ({o, tvalid_out, tlast_out, tdata_out} !== 19'h0) begin
      errors++; $display("FAIL reset_out got o=%h v=%b l=%b d=%b exp all 0", o, tvalid_out, tlast_out, tdata_out); end
    checks++; if ({tready_out_a, tready_out_b} !== 2'b00) begin
      errors++; $display("FAIL reset_ready got a=%b b=%b exp 0 0", tready_out_a, tready_out_b); end
    reset = 1'b0;
    #1;
    checks++; if (tready_out_a !== 1'b1) begin
      errors++; $display("FAIL release_ready_a got %b exp 1", tready_out_a); end
    $display("reset: o=%h tvalid_out=%b tready_a=%b", o, tvalid_out, tready_out_a);
  endtask

  task automatic test_select_a();
    s = 1'b0; a = 16'h2345; b = 16'h1111;
    tvalid_in_a = 1; tvalid_in_b = 1; tlast_in_a = 1; tdata_in_a = 0;
    tlast_in_b = 0; tdata_in_b = 1; tready_in = 1;
    #1;
    checks++; if ({tready_out_a, tready_out_b} !== 2'b10) begin
      errors++; $display("FAIL sel_a_ready got a=%b b=%b exp 1 0", tready_out_a, tready_out_b); end
    tick();
    checks++; if ({o, tvalid_out, tlast_out, tdata_out} !== {16'h2345, 3'b110}) begin
      errors++; $display("FAIL sel_a_out got o=%h v=%b l=%b d=%b exp 2345 1 1 0", o, tvalid_out, tlast_out, tdata_out); end
    $display("select_a: o=%h tlast_out=%b tdata_out=%b", o, tlast_out, tdata_out);
  endtask

  task automatic test_select_b();
    s = 1'b1; a = 16'h8962; b = 16'habcd;
    tlast_in_a = 1; tdata_in_a = 0; tlast_in_b = 0; tdata_in_b = 1;
    #1;
    checks++; if ({tready_out_a, tready_out_b} !== 2'b01) begin
      errors++; $display("FAIL sel_b_ready got a=%b b=%b exp 0 1", tready_out_a, tready_out_b); end
    tick();
    checks++; if ({o, tvalid_out, tlast_out, tdata_out} !== {16'habcd, 3'b101}) begin
      errors++; $display("FAIL sel_b_out got o=%h v=%b l=%b d=%b exp abcd 1 0 1", o, tvalid_out, tlast_out, tdata_out); end
    $display("select_b: o=%h tlast_out=%b tdata_out=%b", o, tlast_out, tdata_out);
  endtask

  task automatic test_tlast_isolation();
    s = 1'b1; b = 16'hffff; tlast_in_a = 1; tlast_in_b = 0;
    tick();
    checks++; if ({o, tlast_out} !== {16'hffff, 1'b0}) begin
      errors++; $display("FAIL tlast_b got o=%h l=%b exp ffff 0", o, tlast_out); end
    $display("tlast_b: o=%h tlast_out=%b", o, tlast_out);
    s = 1'b0; a = 16'hadbc; tlast_in_a = 0; tlast_in_b = 1;
    tick();
    checks++; if ({o, tlast_out} !== {16'hadbc, 1'b0}) begin
      errors++; $display("FAIL tlast_a got o=%h l=%b exp adbc 0", o, tlast_out); end
    $display("tlast_a: o=%h tlast_out=%b", o, tlast_out);
    tvalid_in_a = 0; tvalid_in_b = 0;
    tick();
    checks++; if (tvalid_out !== 1'b0) begin
      errors++; $display("FAIL drain_idle got v=%b exp 0", tvalid_out); end
  endtask

  task automatic test_unselected_ignored();
    s = 1'b0; tvalid_in_a = 0; tvalid_in_b = 1; b = 16'h7777;
    tick();
    checks++; if (tvalid_out !== 1'b0) begin
      errors++; $display("FAIL unsel_valid got v=%b o=%h exp 0", tvalid_out, o); end
    $display("unselected: tvalid_out=%b", tvalid_out);
    tvalid_in_b = 0;
  endtask

  task automatic test_backpressure();
    s = 1'b0; tready_in = 0; tvalid_in_a = 1; a = 16'h0001;
    tlast_in_a = 0; tdata_in_a = 0;
    tick();
    checks++; if ({o, tvalid_out, tready_out_a} !== {16'h0001, 2'b11}) begin
      errors++; $display("FAIL bp_beat1 got o=%h v=%b rdy=%b exp 0001 1 1", o, tvalid_out, tready_out_a); end
    a = 16'h0002;
    tick();
    checks++; if ({o, tready_out_a} !== {16'h0001, 1'b0}) begin
      errors++; $display("FAIL bp_beat2 got o=%h rdy=%b exp 0001 0", o, tready_out_a); end
    a = 16'h0003; tdata_in_a = 1;
    tick();
    checks++; if ({o, tvalid_out, tdata_out} !== {16'h0001, 2'b10}) begin
      errors++; $display("FAIL bp_hold got o=%h v=%b d=%b exp 0001 1 0", o, tvalid_out, tdata_out); end
    s = 1'b1; tvalid_in_b = 1; b = 16'h5555;
    #1;
    checks++; if (tready_out_b !== 1'b0) begin
      errors++; $display("FAIL bp_switch_ready got %b exp 0", tready_out_b); end
    s = 1'b0; tvalid_in_b = 0; tready_in = 1;
    tick();
    checks++; if ({o, tvalid_out, tdata_out, tready_out_a} !== {16'h0002, 3'b101}) begin
      errors++; $display("FAIL bp_out2 got o=%h v=%b d=%b rdy=%b exp 0002 1 0 1", o, tvalid_out, tdata_out, tready_out_a); end
    tick();
    checks++; if ({o, tvalid_out, tdata_out} !== {16'h0003, 2'b11}) begin
      errors++; $display("FAIL bp_out3 got o=%h v=%b d=%b exp 0003 1 1", o, tvalid_out, tdata_out); end
    tvalid_in_a = 0; tdata_in_a = 0;
    tick();
    checks++; if (tvalid_out !== 1'b0) begin
      errors++; $display("FAIL bp_no_dup got v=%b o=%h exp 0", tvalid_out, o); end
    $display("backpressure: stream 1,2,3 drained, tvalid_out=%b", tvalid_out);
  endtask

  task automatic test_reset_midstream();
    s = 1'b0; tready_in = 0; tvalid_in_a = 1; a = 16'h0011;
    tick();
    a = 16'h0022;
    tick();
    checks++; if ({o, tvalid_out, tready_out_a} !== {16'h0011, 2'b10}) begin
      errors++; $display("FAIL mid_full got o=%h v=%b rdy=%b exp 0011 1 0", o, tvalid_out, tready_out_a); end
    reset = 1'b1;
    #1;
    checks++; if ({o, tvalid_out} !== {16'h0000, 1'b0}) begin
      errors++; $display("FAIL mid_reset got o=%h v=%b exp 0000 0", o, tvalid_out); end
    checks++; if ({tready_out_a, tready_out_b} !== 2'b00) begin
      errors++; $display("FAIL mid_reset_ready got a=%b b=%b exp 0 0", tready_out_a, tready_out_b); end
    tvalid_in_a = 0; tready_in = 1;
    tick();
    reset = 1'b0;
    tick();
    checks++; if ({tvalid_out, tready_out_a} !== 2'b01) begin
      errors++; $display("FAIL mid_stale got v=%b o=%h rdy=%b exp 0 1", tvalid_out, o, tready_out_a); end
    tick();
    checks++; if (tvalid_out !== 1'b0) begin
      errors++; $display("FAIL mid_stale2 got v=%b o=%h exp 0", tvalid_out, o); end
    $display("reset_midstream: o=%h tvalid_out=%b", o, tvalid_out);
  endtask

  initial begin
    test_reset();
    test_select_a();
    test_select_b();
    test_tlast_isolation();
    test_unselected_ignored();
    test_backpressure();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
